// File: rtl/lal_seq.sv
// lal_seq: command sequencer wrapped around the combinational lal decoder.
// Commands enter a 2-entry FIFO, are applied to lal, and lal's 9-bit
// next-state output is fed back until it stops changing or the step limit
// is hit. The final state, decode flags and step count are then held on the
// result port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. in_ready depends only on registered state. out_valid and the
// out_* fields stay stable until out_ready is seen, unless abort or reset
// intervenes.
module lal_seq #(
  parameter int MAX_STEPS = 15,
  parameter int CNT_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16:0]       in_cmd,
  input  logic              abort,
  output logic [25:0]       lal_pi,
  input  logic [18:0]       lal_po,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        out_state,
  output logic [8:0]        out_flags,
  output logic [CNT_W-1:0]  out_steps,
  output logic              out_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;

  logic [16:0]       fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              push, pop;

  logic [16:0]       cmd_q;
  logic [8:0]        s_q;
  logic [CNT_W-1:0]  step_q;

  logic [8:0]        n;
  logic              fixed_pt, at_limit, term;
  logic              unused_po9;

  // Bits 7 and 15 of a command carry no meaning; clearing them when the
  // command is loaded lets lal_pi be a plain OR with the freeze bit.
  localparam logic [16:0] CMD_MASK = 17'h17F7F;

  assign in_ready   = (count != 2'd2);
  assign push       = in_valid & in_ready;
  assign pop        = (state_q == IDLE) && (count != 2'd0);

  assign n          = lal_po[18:10];
  assign unused_po9 = lal_po[9];
  assign fixed_pt   = (n == s_q);
  assign at_limit   = (step_q == CNT_W'(MAX_STEPS - 1));
  assign term       = (state_q == RUN) && !abort && (fixed_pt || at_limit);

  // pi15 high freezes lal's chain everywhere except RUN.
  assign lal_pi = {s_q, cmd_q | {1'b0, (state_q != RUN), 15'd0}};

  // Command FIFO: two slots, pointer per side, occupancy counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_cmd;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over termination and over out_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count != 2'd0) state_d = LOAD;
      LOAD: state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort)     state_d = IDLE;
        else if (term) state_d = DONE;
      end
      DONE: begin
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: command capture, chain iteration and result capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q       <= '0;
      s_q         <= '0;
      step_q      <= '0;
      out_valid   <= 1'b0;
      out_state   <= '0;
      out_flags   <= '0;
      out_steps   <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (pop) begin
        cmd_q <= fifo_mem[rd_ptr] & CMD_MASK;
      end
      if (state_q == LOAD) begin
        s_q    <= '0;
        step_q <= '0;
      end else if (state_q == RUN && !abort && !fixed_pt && !at_limit) begin
        s_q    <= n;
        step_q <= step_q + CNT_W'(1);
      end
      if (term) begin
        out_state   <= n;
        out_flags   <= lal_po[8:0];
        out_steps   <= step_q + CNT_W'(1);
        out_timeout <= !fixed_pt;
      end
      out_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_lal_seq.sv
// Bench for lal_seq. A behavioural stand-in for lal closes the loop; a
// reference model walks the chain with plain arithmetic to predict results.
module tb_lal_seq;

  localparam int MAX_STEPS = 15;
  localparam int CNT_W     = 4;
  localparam int RW        = 9 + 9 + CNT_W + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [16:0]       in_cmd;
  logic              abort;
  logic [25:0]       lal_pi;
  logic [18:0]       lal_po;
  logic              out_valid;
  logic              out_ready;
  logic [8:0]        out_state;
  logic [8:0]        out_flags;
  logic [CNT_W-1:0]  out_steps;
  logic              out_timeout;

  int                n_cmp = 0;
  int                n_err = 0;
  logic [RW-1:0]     exp_q[$];
  logic              rnd_ready = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  lal_seq #(.MAX_STEPS(MAX_STEPS), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .abort      (abort),
    .lal_pi     (lal_pi),
    .lal_po     (lal_po),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_flags  (out_flags),
    .out_steps  (out_steps),
    .out_timeout(out_timeout)
  );

  // ---------------- lal stand-in ----------------
  // Chain walks from s toward a limit L = ~{pi[14:8], pi[1:0]} in strides of
  // pi[3:2]+1 and sticks at L. pi15 freezes it; pi7 scrambles it so any
  // leak of that bit shows up as a wrong result.
  function automatic logic [18:0] lal_model(input logic [25:0] pi);
    logic [8:0] s, lim, inc, nx, flags;
    s   = pi[25:17];
    lim = ~{pi[14:8], pi[1:0]};
    inc = {7'd0, pi[3:2]} + 9'd1;
    if (pi[7])                nx = s ^ 9'h0A5;
    else if (pi[15])          nx = s;
    else if (s >= lim)        nx = s;
    else if (lim - s <= inc)  nx = lim;
    else                      nx = s + inc;
    flags = {pi[16], pi[5:0] ^ s[5:0], ^s, pi[15]};
    return {nx, 1'b0, flags};
  endfunction

  always_comb lal_po = lal_model(lal_pi);

  // Reference: iterate the chain for one command until fixed point or limit.
  function automatic logic [RW-1:0] ref_result(input logic [16:0] cmd);
    logic [16:0] c;
    logic [8:0]  s, nx;
    logic [18:0] po;
    c = cmd;
    c[7]  = 1'b0;
    c[15] = 1'b0;
    s = '0;
    for (int st = 1; st <= MAX_STEPS; st++) begin
      po = lal_model({s, c});
      nx = po[18:10];
      if (nx == s)          return {nx, po[8:0], CNT_W'(st), 1'b0};
      if (st == MAX_STEPS)  return {nx, po[8:0], CNT_W'(st), 1'b1};
      s = nx;
    end
    return '0;
  endfunction

  // Mostly commands whose limit is reachable, sometimes fully random ones.
  function automatic logic [16:0] rand_cmd();
    logic [16:0] c;
    c = 17'($urandom);
    if ($urandom_range(0, 3) != 0) c[14:8] = 7'h7F - 7'($urandom_range(0, 3));
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [RW-1:0] cur, prev_out, exp_v;
    logic          prev_valid;
    prev_valid = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clock);
      cur = {out_state, out_flags, out_steps, out_timeout};
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && out_valid) check("hold_stable", cur, prev_out);
        if (out_valid && out_ready && !abort) begin
          check("result_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            check("result", cur, exp_v);
          end
          prev_valid = 1'b0;
        end else begin
          prev_valid = out_valid;
          prev_out   = cur;
        end
      end
    end
  end

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_cmd(input logic [16:0] c);
    logic ok;
    ok = 1'b0;
    in_cmd   = c;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accepted", ok, 1);
    if (ok) exp_q.push_back(ref_result(c));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1);
    tick();
  endtask

  task automatic wait_run();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (!lal_pi[15]) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_run", seen, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !out_valid && lal_pi[15]) break;
    end
    check("drain", exp_q.size(), 0);
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [16:0] cmd_d;
    reset = 1'b1;
    in_valid = 1'b0;
    in_cmd = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_lal_pi", lal_pi, 26'h0008000);
    check("reset_out_fields", {out_state, out_flags, out_steps, out_timeout}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Chain progression: cmd 0 counts up by one and never settles.
    out_ready = 1'b1;
    push_cmd(17'h00000);
    wait_run();
    for (int k = 0; k < 4; k++) begin
      check("chain_s", lal_pi[25:17], k);
      @(negedge clock);
    end
    tick();
    drain();

    // Directed fixed points: immediate, and after a few steps.
    push_cmd(17'h07F03);
    push_cmd(17'h07F00);
    push_cmd(17'h1FFFF);
    drain();

    // Random commands with random consumer backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      push_cmd(rand_cmd());
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_ready = 1'b0;
    tick();
    drain();

    // Backpressure: first result parked in DONE, FIFO fills, fourth waits.
    out_ready = 1'b0;
    push_cmd(rand_cmd());
    wait_valid("bp_first_done");
    push_cmd(rand_cmd());
    push_cmd(rand_cmd());
    @(negedge clock);
    check("bp_full", in_ready, 0);
    tick();
    in_cmd = rand_cmd();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_blocked", in_ready, 0);
    end
    tick();
    cmd_d = rand_cmd();
    out_ready = 1'b1;
    push_cmd(cmd_d);
    drain();

    // Abort in the second RUN cycle of A with B queued.
    push_cmd(17'h00000);
    push_cmd(rand_cmd());
    wait_run();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete(0);
    @(negedge clock);
    check("abort_to_idle", lal_pi[15], 1);
    check("abort_no_valid", out_valid, 0);
    tick();
    drain();

    // Abort while IDLE pops: must be ignored.
    push_cmd(rand_cmd());
    abort = 1'b1;
    tick();
    abort = 1'b0;
    drain();

    // Abort in DONE together with out_ready: result is dropped.
    out_ready = 1'b0;
    push_cmd(rand_cmd());
    wait_valid("abort_done_reach");
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    exp_q.delete(0);
    @(negedge clock);
    check("abort_done_valid", out_valid, 0);
    tick();
    drain();

    // Push in the same cycle IDLE pops with one entry queued.
    out_ready = 1'b0;
    push_cmd(rand_cmd());
    wait_valid("pp_a_done");
    push_cmd(rand_cmd());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cmd_d = rand_cmd();
    in_cmd = cmd_d;
    in_valid = 1'b1;
    @(negedge clock);
    check("pp_ready", in_ready, 1);
    if (in_ready) exp_q.push_back(ref_result(cmd_d));
    tick();
    in_valid = 1'b0;
    wait_valid("pp_b_done");
    push_cmd(rand_cmd());
    @(negedge clock);
    check("pp_full", in_ready, 0);
    tick();
    drain();

    // Reset mid-RUN with two entries queued.
    out_ready = 1'b1;
    push_cmd(17'h00000);
    push_cmd(rand_cmd());
    push_cmd(rand_cmd());
    wait_run();
    #2;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_lal_pi", lal_pi, 26'h0008000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("rst_stay_idle", {out_valid, lal_pi}, {1'b0, 26'h0008000});
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
